// File: rtl/wb_thresh_bank_if.sv
// Wishbone slave bus bundle for the threshold bank.
// The master drives the request side and the slave drives the response side.
interface wb_thresh_bank_if #(
    parameter int AW = 5
);
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [AW-1:0] wb_adr_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic [31:0]   wb_dat_i;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;
    logic          wb_stall_o;
    logic [31:0]   wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i,
        input  wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i,
        output wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
    );
endinterface

// File: rtl/wb_thresh_bank.sv
// Bank of NCH high/low threshold pairs behind a Wishbone slave port, with
// direct or shadowed (commit-on-demand) update of the active thresholds.
module wb_thresh_bank #(
    parameter int NCH = 4,
    parameter int TW  = 16,
    parameter int AW  = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    wb_thresh_bank_if.slave   wb,
    output logic [NCH*TW-1:0] thr_high_o,
    output logic [NCH*TW-1:0] thr_low_o,
    output logic              commit_o
);

    localparam logic [AW-1:0] CTRL_ADR = AW'(NCH);

    if ((2**AW <= NCH) || (NCH < 1) || (NCH > 16) || (TW < 1) || (TW > 16)) begin : g_param_check
        $error("wb_thresh_bank: illegal NCH/TW/AW combination");
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{sel[k]}};
        return m;
    endfunction

    function automatic logic [31:0] pack_word(input logic [TW-1:0] hi, input logic [TW-1:0] lo);
        logic [31:0] w;
        w          = '0;
        w[16 +: TW] = hi;
        w[0 +: TW]  = lo;
        return w;
    endfunction

    logic [TW-1:0] sh_high  [NCH];
    logic [TW-1:0] sh_low   [NCH];
    logic [TW-1:0] act_high [NCH];
    logic [TW-1:0] act_low  [NCH];
    logic          mode, pending;

    logic          rd_busy, wr_busy;
    logic          vld_p1;
    logic [AW-1:0] wr_adr_p1;
    logic [TW-1:0] wr_hi_p1, wr_lo_p1, wr_hm_p1, wr_lm_p1;
    logic [1:0]    wr_ctl_p1;
    logic          wr_sel0_p1;

    logic          req, rd_req, wr_req;
    logic          rd_hit, wr_chan_hit, wr_hit_p1, wr_chan, wr_ctrl, do_commit;
    logic [31:0]   rd_word, req_mask;
    logic [TW-1:0] old_high, old_low, new_high, new_low;

    // Busy flops block re-detection while the master holds stb for the response.
    assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~rd_busy & ~wr_busy;
    assign rd_req = req & ~wb.wb_we_i;
    assign wr_req = req &  wb.wb_we_i;

    assign req_mask = lane_mask(wb.wb_sel_i);

    always_comb begin
        rd_word = '0;
        rd_hit  = 1'b0;
        if (wb.wb_adr_i == CTRL_ADR) begin
            rd_hit  = 1'b1;
            rd_word = {29'b0, pending, 1'b0, mode};
        end
        for (int c = 0; c < NCH; c++) begin
            if (wb.wb_adr_i == AW'(c)) begin
                rd_hit  = 1'b1;
                rd_word = pack_word(sh_high[c], sh_low[c]);
            end
        end
    end

    always_comb begin
        old_high    = '0;
        old_low     = '0;
        wr_chan_hit = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (wr_adr_p1 == AW'(c)) begin
                wr_chan_hit = 1'b1;
                old_high    = sh_high[c];
                old_low     = sh_low[c];
            end
        end
    end

    assign new_high  = (old_high & ~wr_hm_p1) | (wr_hi_p1 & wr_hm_p1);
    assign new_low   = (old_low  & ~wr_lm_p1) | (wr_lo_p1 & wr_lm_p1);
    assign wr_hit_p1 = wr_chan_hit | (wr_adr_p1 == CTRL_ADR);
    assign wr_chan   = vld_p1 & wr_chan_hit;
    assign wr_ctrl   = vld_p1 & (wr_adr_p1 == CTRL_ADR) & wr_sel0_p1;
    // Explicit COMMIT, or leaving shadowed mode with unpublished shadow writes.
    assign do_commit = wr_ctrl & (wr_ctl_p1[1] | (pending & ~wr_ctl_p1[0]));

    // Stage p0 -> p1: request capture and read response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_busy      <= 1'b0;
            wr_busy      <= 1'b0;
            vld_p1       <= 1'b0;
            wr_adr_p1    <= '0;
            wr_hi_p1     <= '0;
            wr_lo_p1     <= '0;
            wr_hm_p1     <= '0;
            wr_lm_p1     <= '0;
            wr_ctl_p1    <= '0;
            wr_sel0_p1   <= 1'b0;
            wb.wb_ack_o  <= 1'b0;
            wb.wb_err_o  <= 1'b0;
            wb.wb_dat_o  <= '0;
        end else begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            wb.wb_dat_o <= '0;
            vld_p1      <= 1'b0;
            if (rd_busy) rd_busy <= 1'b0;
            if (wr_busy && (wb.wb_ack_o || wb.wb_err_o)) wr_busy <= 1'b0;
            if (rd_req) begin
                rd_busy     <= 1'b1;
                wb.wb_ack_o <= rd_hit;
                wb.wb_err_o <= ~rd_hit;
                wb.wb_dat_o <= rd_word;
            end
            if (wr_req) begin
                wr_busy    <= 1'b1;
                vld_p1     <= 1'b1;
                wr_adr_p1  <= wb.wb_adr_i;
                wr_hi_p1   <= wb.wb_dat_i[16 +: TW];
                wr_lo_p1   <= wb.wb_dat_i[0 +: TW];
                wr_hm_p1   <= req_mask[16 +: TW];
                wr_lm_p1   <= req_mask[0 +: TW];
                wr_ctl_p1  <= wb.wb_dat_i[1:0];
                wr_sel0_p1 <= wb.wb_sel_i[0];
            end
            // Stage p1 -> p2: write response
            if (vld_p1) begin
                wb.wb_ack_o <= wr_hit_p1;
                wb.wb_err_o <= ~wr_hit_p1;
            end
        end
    end

    // Stage p1 -> p2: register bank update
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < NCH; c++) begin
                sh_high[c]  <= '1;
                sh_low[c]   <= '0;
                act_high[c] <= '1;
                act_low[c]  <= '0;
            end
            mode     <= 1'b0;
            pending  <= 1'b0;
            commit_o <= 1'b0;
        end else begin
            commit_o <= do_commit;
            for (int c = 0; c < NCH; c++) begin
                if (wr_chan && (wr_adr_p1 == AW'(c))) begin
                    sh_high[c] <= new_high;
                    sh_low[c]  <= new_low;
                    if (!mode) begin
                        act_high[c] <= new_high;
                        act_low[c]  <= new_low;
                    end
                end
            end
            if (wr_chan && mode) pending <= 1'b1;
            if (wr_ctrl) mode <= wr_ctl_p1[0];
            if (do_commit) begin
                pending <= 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    act_high[c] <= sh_high[c];
                    act_low[c]  <= sh_low[c];
                end
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_out
        assign thr_high_o[c*TW +: TW] = act_high[c];
        assign thr_low_o[c*TW +: TW]  = act_low[c];
    end

    assign wb.wb_rty_o   = 1'b0;
    assign wb.wb_stall_o = wb.wb_cyc_i & wb.wb_stb_i & ~(wb.wb_ack_o | wb.wb_err_o);

endmodule

// File: tb/tb_wb_thresh_bank.sv
// Directed bench for wb_thresh_bank (NCH=4, TW=12) with a register-level
// model of the threshold bank checked every cycle plus literal spot checks.
module tb_wb_thresh_bank;

    localparam int NCH = 4;
    localparam int TW  = 12;
    localparam int AW  = 5;

    logic clk;
    logic rst_n;
    logic [NCH*TW-1:0] thr_high, thr_low;
    logic commit;

    wb_thresh_bank_if #(.AW(AW)) wb ();

    wb_thresh_bank #(.NCH(NCH), .TW(TW), .AW(AW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wb         (wb),
        .thr_high_o (thr_high),
        .thr_low_o  (thr_low),
        .commit_o   (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int commit_at = -1;

    logic [TW-1:0] m_sh_high [NCH];
    logic [TW-1:0] m_sh_low  [NCH];
    logic [TW-1:0] m_act_high[NCH];
    logic [TW-1:0] m_act_low [NCH];
    bit            m_mode, m_pending;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sh_high[c]  = '1;
            m_sh_low[c]   = '0;
            m_act_high[c] = '1;
            m_act_low[c]  = '0;
        end
        m_mode    = 1'b0;
        m_pending = 1'b0;
        commit_at = -1;
    endtask

    function automatic logic [31:0] m_read(input int adr);
        if (adr < NCH) return (32'(m_sh_high[adr]) << 16) | 32'(m_sh_low[adr]);
        if (adr == NCH) return {29'b0, m_pending, 1'b0, m_mode};
        return 32'h0;
    endfunction

    task automatic m_write(input int adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] mask, w;
        bit          do_commit;
        for (int k = 0; k < 4; k++) mask[8*k +: 8] = sel[k] ? 8'hFF : 8'h00;
        if (adr < NCH) begin
            w = (m_read(adr) & ~mask) | (dat & mask);
            m_sh_high[adr] = w[16 +: TW];
            m_sh_low[adr]  = w[0 +: TW];
            if (m_mode) m_pending = 1'b1;
            else begin
                m_act_high[adr] = m_sh_high[adr];
                m_act_low[adr]  = m_sh_low[adr];
            end
        end else if (adr == NCH && sel[0]) begin
            do_commit = dat[1] || (m_pending && !dat[0]);
            m_mode    = dat[0];
            if (do_commit) begin
                for (int c = 0; c < NCH; c++) begin
                    m_act_high[c] = m_sh_high[c];
                    m_act_low[c]  = m_sh_low[c];
                end
                m_pending = 1'b0;
                commit_at = ncyc;
            end
        end
    endtask

    // Every-cycle comparison of outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("thr_high_ch%0d", c), thr_high[c*TW +: TW], m_act_high[c]);
                chk($sformatf("thr_low_ch%0d", c),  thr_low[c*TW +: TW],  m_act_low[c]);
            end
            chk("commit_pulse", commit, (commit_at == ncyc));
            chk("stall", wb.wb_stall_o, wb.wb_cyc_i & wb.wb_stb_i & ~(wb.wb_ack_o | wb.wb_err_o));
            chk("rty", wb.wb_rty_o, 1'b0);
            chk("ack_err_excl", wb.wb_ack_o & wb.wb_err_o, 1'b0);
            ncyc++;
        end
    end

    task automatic bus(input bit we, input int adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat);
        int          lat;
        bit          seen;
        bit          exp_err;
        logic [31:0] exp_rd;
        exp_err = (adr > NCH);
        exp_rd  = m_read(adr);
        rdat    = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = we;
        wb.wb_adr_i = AW'(adr);
        wb.wb_dat_i = dat;
        wb.wb_sel_i = sel;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (wb.wb_ack_o || wb.wb_err_o) seen = 1;
        end
        chk($sformatf("resp_seen_adr%0d", adr), seen, 1'b1);
        if (seen) begin
            chk($sformatf("latency_adr%0d", adr), lat, we ? 2 : 1);
            chk($sformatf("ack_adr%0d", adr), wb.wb_ack_o, !exp_err);
            chk($sformatf("err_adr%0d", adr), wb.wb_err_o, exp_err);
            rdat = wb.wb_dat_o;
            if (!we) chk($sformatf("rdata_adr%0d", adr), wb.wb_dat_o, exp_rd);
            if (we) m_write(adr, dat, sel);
        end
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input int adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] unused;
        bus(1'b1, adr, dat, sel, unused);
    endtask

    task automatic rd(input int adr, output logic [31:0] rdat);
        bus(1'b0, adr, 32'h0, 4'hF, rdat);
    endtask

    logic [31:0] r;

    initial begin
        rst_n       = 1'b0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        wb.wb_sel_i = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", wb.wb_ack_o, 1'b0);
        chk("rst_dat", wb.wb_dat_o, 32'h0);
        rst_n = 1'b1;

        // reset state
        chk("rst_thr_high", thr_high, 48'hFFF_FFF_FFF_FFF);
        chk("rst_thr_low", thr_low, 48'h0);
        rd(0, r);       chk("rst_rd_ch0", r, 32'h0FFF_0000);
        rd(NCH, r);     chk("rst_rd_ctrl", r, 32'h0);

        // direct-mode write of channel 2
        wr(2, 32'h0ABC_0123, 4'hF);
        chk("direct_ch2_high", thr_high[2*TW +: TW], 12'hABC);
        chk("direct_ch2_low", thr_low[2*TW +: TW], 12'h123);
        rd(2, r);       chk("direct_ch2_rd", r, 32'h0ABC_0123);

        // commit without anything pending still pulses
        wr(NCH, 32'h2, 4'h1);
        rd(NCH, r);     chk("nopend_commit_ctrl", r, 32'h0);

        // shadowed mode, explicit commit
        wr(NCH, 32'h1, 4'h1);
        wr(0, 32'h0064_0032, 4'hF);
        chk("shadow_ch0_high_held", thr_high[0 +: TW], 12'hFFF);
        chk("shadow_ch0_low_held", thr_low[0 +: TW], 12'h000);
        rd(NCH, r);     chk("shadow_pending", r, 32'h5);
        rd(0, r);       chk("shadow_rd_ch0", r, 32'h0064_0032);
        wr(NCH, 32'h3, 4'h1);
        chk("commit_ch0_high", thr_high[0 +: TW], 12'h064);
        chk("commit_ch0_low", thr_low[0 +: TW], 12'h032);
        rd(NCH, r);     chk("commit_ctrl", r, 32'h1);

        // implicit commit on leaving shadowed mode
        wr(3, 32'h0123_0456, 4'hF);
        chk("impl_ch3_held", thr_high[3*TW +: TW], 12'hFFF);
        wr(NCH, 32'h0, 4'h1);
        rd(NCH, r);     chk("impl_ctrl", r, 32'h0);
        chk("impl_ch3_high", thr_high[3*TW +: TW], 12'h123);
        chk("impl_ch3_low", thr_low[3*TW +: TW], 12'h456);

        // byte lanes
        wr(1, 32'hFFFF_FFFF, 4'h4);
        chk("lane_ch1_high", thr_high[1*TW +: TW], 12'hFFF);
        chk("lane_ch1_low", thr_low[1*TW +: TW], 12'h000);
        wr(3, 32'h0, 4'hF);
        wr(3, 32'hFFFF_FFFF, 4'h4);
        chk("lane2_ch3_high", thr_high[3*TW +: TW], 12'h0FF);
        wr(3, 32'hFFFF_FFFF, 4'h8);
        chk("lane3_ch3_high", thr_high[3*TW +: TW], 12'hFFF);
        wr(3, 32'hFFFF_FFFF, 4'h1);
        rd(3, r);       chk("lanes_ch3_rd", r, 32'h0FFF_00FF);

        // CTRL write without sel[0] does nothing
        wr(NCH, 32'h3, 4'h2);
        rd(NCH, r);     chk("ctrl_nosel0", r, 32'h0);

        // unmapped accesses
        rd(7, r);       chk("unmap_rd7_dat", r, 32'h0);
        rd(NCH + 1, r); chk("unmap_rd5_dat", r, 32'h0);
        wr(7, 32'hFFFF_FFFF, 4'hF);
        rd(NCH, r);     chk("unmap_ctrl", r, 32'h0);
        rd(2, r);       chk("unmap_ch2", r, 32'h0ABC_0123);

        // reset one cycle after a write request
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = 1'b1;
        wb.wb_adr_i = AW'(2);
        wb.wb_dat_i = 32'h0555_0AAA;
        wb.wb_sel_i = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        m_reset();
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        #1;
        chk("abort_ack", wb.wb_ack_o, 1'b0);
        chk("abort_thr_high", thr_high, 48'hFFF_FFF_FFF_FFF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_late_ack", wb.wb_ack_o | wb.wb_err_o, 1'b0);
        end
        chk("abort_thr_low", thr_low, 48'h0);
        rd(2, r);       chk("abort_rd_ch2", r, 32'h0FFF_0000);
        rd(NCH, r);     chk("abort_ctrl", r, 32'h0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
